mux41_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4-to-1 datapath mux between four requesters.
- Drives the mux's 2-bit select line, a one-hot grant vector and a select-valid qualifier.
- Sits beside the 32-bit 4:1 mux, for example on a shared write-back or memory-port path.
- An owner keeps the path until it releases its request, with optional starvation-prevention preemption.

---
 rtl/mux41_rr_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mux41_rr_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mux41_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mux41_rr_arbiter                                              |
// | Purpose  : Round-robin arbiter that owns the select line of a shared     |
// |            4:1 datapath mux. A granted requester keeps the path until it |
// |            drops its request; ownership then passes straight to the next |
// |            round-robin winner with no idle cycle in between.             |
// | Ports    : clk       - rising-edge clock                                 |
// |            rst_n     - asynchronous active-low reset                     |
// |            req[3:0]  - level requests, held until granted/done           |
// |            gnt[3:0]  - registered one-hot grant, zero when idle          |
// |            sel[1:0]  - registered mux select, holds last owner when idle |
// |            sel_valid - registered, high while gnt is non-zero            |
// |            busy      - registered, high while a requester owns the path  |
// | Options  : ARB_TIMEOUT_EN - when defined, an owner that has held the     |
// |            grant for MAX_HOLD counted cycles while others wait is        |
// |            preempted. When undefined, MAX_HOLD and CNT_W are unused.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mux41_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       sel_valid,
  output logic       busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_gnt, w_gnt_nxt;
  logic [1:0] r_sel, w_sel_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic       r_sel_valid, w_sel_valid_nxt;
  logic       r_busy, w_busy_nxt;

  logic [3:0] w_owner_oh;
  logic       w_owner_req;
  logic       w_others_req;
  logic [3:0] w_cand;
  logic [1:0] w_pick_idx;
  logic       w_pick_vld;
  logic       w_new_grant;
  logic       w_preempt;

  assign w_owner_oh   = 4'b0001 << r_sel;
  assign w_owner_req  = req[r_sel];
  assign w_others_req = |(req & ~w_owner_oh);

  // While owning, the current owner is excluded from the pick so that a
  // handover (release or preemption) always moves to a different requester.
  assign w_cand = (r_state == ST_OWN) ? (req & ~w_owner_oh) : req;

  // Scan ptr+1 .. ptr+4 (mod 4); the 2-bit add wraps naturally.
  always_comb begin
    logic [1:0] v_idx;
    v_idx      = r_ptr;
    w_pick_vld = 1'b0;
    w_pick_idx = r_ptr;
    for (int i = 1; i <= 4; i++) begin
      v_idx = r_ptr + 2'(i);
      if (!w_pick_vld && w_cand[v_idx]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = v_idx;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_nxt;

  // Preemption only matters when someone else is actually waiting.
  assign w_preempt = (r_state == ST_OWN) && w_owner_req && w_others_req &&
                     (r_hold_cnt == CNT_W'(MAX_HOLD));

  always_comb begin
    w_hold_cnt_nxt = r_hold_cnt;
    if (w_new_grant) begin
      w_hold_cnt_nxt = '0;
    end else if ((r_state == ST_OWN) && w_owner_req &&
                 (r_hold_cnt != CNT_W'(MAX_HOLD))) begin
      w_hold_cnt_nxt = r_hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else begin
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end
`else
  logic [CNT_W-1:0] w_unused_max_hold;
  assign w_unused_max_hold = CNT_W'(MAX_HOLD);
  assign w_preempt         = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_sel_nxt       = r_sel;
    w_ptr_nxt       = r_ptr;
    w_sel_valid_nxt = r_sel_valid;
    w_busy_nxt      = r_busy;
    w_new_grant     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_new_grant = 1'b1;
        end
      end
      ST_OWN: begin
        if (!w_owner_req || w_preempt) begin
          if (w_pick_vld) begin
            w_new_grant = 1'b1;
          end else begin
            // sel deliberately keeps the last owner.
            w_state_nxt     = ST_IDLE;
            w_gnt_nxt       = 4'b0000;
            w_sel_valid_nxt = 1'b0;
            w_busy_nxt      = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_new_grant) begin
      w_state_nxt     = ST_OWN;
      w_gnt_nxt       = 4'b0001 << w_pick_idx;
      w_sel_nxt       = w_pick_idx;
      w_ptr_nxt       = w_pick_idx;
      w_sel_valid_nxt = 1'b1;
      w_busy_nxt      = 1'b1;
    end
  end

  // ptr resets to 3 so requester 0 is first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt       <= 4'b0000;
      r_sel       <= 2'b00;
      r_ptr       <= 2'b11;
      r_sel_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_sel       <= w_sel_nxt;
      r_ptr       <= w_ptr_nxt;
      r_sel_valid <= w_sel_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign sel_valid = r_sel_valid;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mux41_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mux41_rr_arbiter                                           |
// | Purpose  : Directed self-checking bench for mux41_rr_arbiter. Observed   |
// |            value is packed as {gnt[3:0], sel[1:0], sel_valid, busy}.     |
// |            Follows ARB_TIMEOUT_EN for the hold-limit scenarios.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mux41_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       sel_valid;
  logic       busy;

  int n_cmp;
  int n_err;

  mux41_rr_arbiter #(
    .MAX_HOLD (4),
    .CNT_W    (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .sel_valid (sel_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp_v);
    logic [7:0] obs;
    obs = {gnt, sel, sel_valid, busy};
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed {gnt,sel,vld,busy}=%b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] own(input int idx);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    return {oh, 2'(idx), 1'b1, 1'b1};
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = 4'b0000;

    // 1: reset state, single grant, release
    #12;
    chk("reset", 8'b0000_00_0_0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_req", 8'b0000_00_0_0);
    req = 4'b0001;
    tick();
    chk("grant0", own(0));
    req = 4'b0000;
    tick();
    chk("release0", 8'b0000_00_0_0);

    // 2: full contention, each owner keeps 3 cycles, order 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_own%0d_c1", k), own(k % 4));
      req = 4'b1111;
      tick();
      chk($sformatf("rr_own%0d_c2", k), own(k % 4));
      tick();
      chk($sformatf("rr_own%0d_c3", k), own(k % 4));
      req = 4'b1111 & ~(4'b0001 << (k % 4));
      tick();
    end
    chk("rr_wrap_to1", own(1));
    req = 4'b0000;
    tick();
    chk("rr_idle_sel_hold", 8'b0000_01_0_0);

    // 3: pulse on a non-owner is ignored, then release to idle
    req = 4'b0100;
    tick();
    chk("own2", own(2));
    req = 4'b0101;
    tick();
    chk("own2_pulse", own(2));
    req = 4'b0100;
    tick();
    chk("own2_after_pulse", own(2));
    req = 4'b0000;
    tick();
    chk("own2_release", 8'b0000_10_0_0);

    // 4: asynchronous reset mid-ownership
    req = 4'b0010;
    tick();
    chk("own1", own(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 8'b0000_00_0_0);
    #1;
    rst_n = 1'b1;
    req   = 4'b1000;
    tick();
    chk("post_reset_own3", own(3));
    req = 4'b0111;
    tick();
    chk("handover_to0", own(0));

    // single owner reasserting after a one-cycle gap
    req = 4'b0000;
    tick();
    chk("own0_drop", 8'b0000_00_0_0);
    req = 4'b0001;
    tick();
    chk("own0_regrant", own(0));

    // 5: two continuous requesters
    do_reset();
    req = 4'b0011;
    tick();
    for (int i = 0; i < 20; i++) begin
`ifdef ARB_TIMEOUT_EN
      chk($sformatf("hold_pair_c%0d", i), own((i / 5) % 2));
`else
      chk($sformatf("hold_pair_c%0d", i), own(0));
`endif
      tick();
    end

    // 6: lone requester never preempted
    do_reset();
    req = 4'b1000;
    tick();
    for (int i = 0; i < 22; i++) begin
      chk($sformatf("lone3_c%0d", i), own(3));
      tick();
    end
    req = 4'b0000;
    tick();
    chk("lone3_release", 8'b0000_11_0_0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
